ped_request_if: RTL
===================

Name: ped_request_if

Overview:
Pedestrian-side front end for traffic_control: the initiator end of the PA/PB to RA/RB request/acknowledge interface.
- Synchronises and debounces two raw crosswalk buttons.
- Issues a held request per direction until the controller acknowledges it.
- Drives the WAIT lamps.
- Drives traffic_control's ERR input on a stuck button or an acknowledge timeout.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronised samples required to change the debounced button level.
- STUCK_CYCLES, 1000: debounced-high cycles after which a button is declared stuck.
- ACK_TIMEOUT, 256: cycles in REQ without RA/RB before the channel faults.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- BTN_A  in  1  raw asynchronous button, direction A.
- BTN_B  in  1  raw asynchronous button, direction B.
- RA  in  1  request-acknowledge level from traffic_control, direction A.
- RB  in  1  request-acknowledge level from traffic_control, direction B.
- ERR_CLR  in  1  synchronous clear of fault/error state.
- PA  out  1  registered request to traffic_control, direction A.
- PB  out  1  registered request to traffic_control, direction B.
- WAIT_A  out  1  pedestrian WAIT lamp, direction A.
- WAIT_B  out  1  pedestrian WAIT lamp, direction B.
- ERR  out  1  registered error to traffic_control.

Behaviour:
- Reset (reset=0, asynchronous):
  - PA=PB=0, WAIT_A=WAIT_B=0, ERR=0.
  - Synchroniser flops, debounced levels, all counters and stuck flags = 0.
  - Both channel FSMs = IDLE.
  - Reset applied mid-request drops PA/PB in the same instant, with no acknowledge wait.
- Sync: 2-flop synchroniser per button.
- Debounce:
  - Counter runs while the synchronised level differs from the debounced level; it resets to 0 on any match.
  - The debounced level flips when the count reaches DEB_CYCLES.
- Latency: PA/PB rises on the (2+DEB_CYCLES+1)th rising edge after the first edge sampling BTN high, i.e. 7 edges at defaults.
- Per-channel FSM (shown for A; B is identical with PB/RB/WAIT_B):
  - IDLE: PA=0, WAIT_A=0. A debounced rising edge moves to REQ.
  - REQ: PA=1, WAIT_A=1, timer increments each cycle. RA=1 moves to ACK. Timer == ACK_TIMEOUT-1 with RA=0 moves to FAULT.
  - ACK: PA=0, WAIT_A=1. RA=0 moves to IDLE.
  - FAULT: PA=0, WAIT_A=0, fault flag=1. ERR_CLR=1 moves to IDLE.
- Additional presses in REQ/ACK/FAULT are ignored, not queued; a press must produce a fresh debounced rising edge in IDLE.
- Simultaneous events:
  - RA=1 in the timeout cycle: ACK wins.
  - ERR_CLR in the same cycle as a debounced rise while in FAULT: clear wins and the rise is discarded.
  - A and B are fully independent; both may be in REQ at once.
- Stuck detection:
  - Counter of debounced-high cycles, saturating at STUCK_CYCLES.
  - Stuck flag sets at STUCK_CYCLES.
  - Without sticky mode, the stuck flag clears when the debounced level falls.
- ERR: registered, ERR = stuck_a | stuck_b | fault_a | fault_b, one cycle after the flag changes.
- Widths: counters sized $clog2(param+1); all arithmetic unsigned and saturating, never wrapping.

Optional Feature:
- Macro TLC_ERR_STICKY_EN.
- Defined: ERR latches high on any flag and stays high until ERR_CLR=1 or reset, even if the button is released or the flag clears. ERR_CLR also clears the stuck flags.
- Undefined: ERR follows the OR of the current flags, one cycle late. ERR_CLR affects only FAULT states.

Decomposition:
- Package tlc_pkg holds:
  - the channel state typedef (IDLE=2'b00, REQ=2'b01, ACK=2'b10, FAULT=2'b11);
  - default parameter constants;
  - the traffic_control light encodings, shared with the controller.
- Sub-module ped_chan: synchroniser, debouncer, stuck counter, FSM and timer for one direction. Instantiated twice.
- The top level holds only the ERR register and the sticky logic.

Test Plan:
- Reset and release, BTN_A pressed clean for 20 cycles with RA rising 3 cycles after PA -> PA high exactly 7 edges after the press, PA low the edge after RA=1, WAIT_A stays high until RA falls, ERR=0.
- BTN_B bounces 1-0-1-0 at 2-cycle spacing, then holds high -> exactly one PB request, PB not asserted until 4 stable samples.
- BTN_A pressed, RA held 0 -> PA drops and ERR=1 after 256 cycles in REQ; a second press is ignored; ERR_CLR pulse returns the channel to IDLE and ERR to 0 (non-sticky).
- BTN_B held 1000+ cycles with RB acknowledging -> ERR rises at stuck count 1000; release -> ERR falls (undefined) or stays until ERR_CLR (TLC_ERR_STICKY_EN).
- Both buttons pressed on the same edge, RA/RB acknowledged on different cycles -> PA/PB rise together and fall independently.
- reset=0 asserted asynchronously mid-REQ, between clock edges -> PA, WAIT_A and ERR go to 0 immediately; after release no request is issued without a new press.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types and constants for the pedestrian request front end and traffic_control.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package tlc_pkg;

    // Per-direction request channel state.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        ACK   = 2'b10,
        FAULT = 2'b11
    } chan_state_t;

    // Default timing parameters.
    localparam int DEF_DEB_CYCLES   = 4;
    localparam int DEF_STUCK_CYCLES = 1000;
    localparam int DEF_ACK_TIMEOUT  = 256;

    // Light encodings driven by traffic_control, kept here so both ends agree.
    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_GREEN  = 2'b10,
        LIGHT_OFF    = 2'b11
    } light_t;

    // Bits needed for a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ped_chan.sv
// One pedestrian direction: sync, debounce, stuck detect, request FSM with ack timeout.
// Latency: request rises 2 + DEB_CYCLES + 1 edges after the first edge sampling the button high.
// Backpressure: request is held until ack; presses outside IDLE are dropped, not queued.
// Optional: TLC_ERR_STICKY_EN makes the stuck flag hold until err_clr.
module ped_chan
    import tlc_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic ack,
    input  logic err_clr,
    output logic req,
    output logic wait_lamp,
    output logic fault,
    output logic stuck
);

    localparam int DW = cnt_width(DEB_CYCLES);
    localparam int SW = cnt_width(STUCK_CYCLES);
    localparam int TW = cnt_width(ACK_TIMEOUT);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          deb_prev_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic          stuck_q, stuck_d;
    chan_state_t   state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          req_q, req_d;
    logic          wait_q, wait_d;
    logic          fault_q, fault_d;
    logic          deb_rise;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive disagreeing samples; flip on the DEB_CYCLES-th one.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q >= DEB_LAST) begin
                deb_d     = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Stuck detect: saturating count of debounced-high cycles.
    always_comb begin
        stuck_cnt_d = '0;
        if (deb_q) begin
            stuck_cnt_d = (stuck_cnt_q >= STUCK_MAX) ? STUCK_MAX : stuck_cnt_q + 1'b1;
        end
`ifdef TLC_ERR_STICKY_EN
        stuck_d = err_clr ? 1'b0 : (stuck_q | (stuck_cnt_d >= STUCK_MAX));
`else
        stuck_d = (stuck_cnt_d >= STUCK_MAX);
`endif
    end

    assign deb_rise = deb_q & ~deb_prev_q;

    // Channel FSM next state, ack timer and decoded outputs (registered below).
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (deb_rise) state_d = REQ;
            end
            REQ: begin
                // Ack takes priority over a timeout in the same cycle.
                if (ack) begin
                    state_d = ACK;
                    tmr_d   = '0;
                end else if (tmr_q >= TMO_LAST) begin
                    state_d = FAULT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ACK: begin
                if (!ack) state_d = IDLE;
            end
            FAULT: begin
                // A rise arriving with the clear is simply lost: IDLE only acts on new rises.
                if (err_clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_d   = (state_d == REQ);
        wait_d  = (state_d == REQ) || (state_d == ACK);
        fault_d = (state_d == FAULT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q       <= 1'b0;
            deb_prev_q  <= 1'b0;
            deb_cnt_q   <= '0;
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
            state_q     <= IDLE;
            tmr_q       <= '0;
            req_q       <= 1'b0;
            wait_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            deb_cnt_q   <= deb_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
            stuck_q     <= stuck_d;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            req_q       <= req_d;
            wait_q      <= wait_d;
            fault_q     <= fault_d;
        end
    end

    assign req       = req_q;
    assign wait_lamp = wait_q;
    assign fault     = fault_q;
    assign stuck     = stuck_q;

endmodule

// File: rtl/ped_request_if.sv
// Pedestrian request initiator toward traffic_control: two channels plus the ERR register.
// Latency: PA/PB 7 edges after press at defaults; ERR one edge after any flag change.
// Backpressure: PA/PB held until RA/RB; ERR_CLR releases faults (and stuck/ERR when TLC_ERR_STICKY_EN).
module ped_request_if
    import tlc_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
    input  logic CLK,
    input  logic reset,
    input  logic BTN_A,
    input  logic BTN_B,
    input  logic RA,
    input  logic RB,
    input  logic ERR_CLR,
    output logic PA,
    output logic PB,
    output logic WAIT_A,
    output logic WAIT_B,
    output logic ERR
);

    logic fault_a, fault_b, stuck_a, stuck_b;
    logic flags;
    logic err_q, err_d;

    ped_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_chan_a (
        .clk      (CLK),
        .rst_n    (reset),
        .btn      (BTN_A),
        .ack      (RA),
        .err_clr  (ERR_CLR),
        .req      (PA),
        .wait_lamp(WAIT_A),
        .fault    (fault_a),
        .stuck    (stuck_a)
    );

    ped_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_chan_b (
        .clk      (CLK),
        .rst_n    (reset),
        .btn      (BTN_B),
        .ack      (RB),
        .err_clr  (ERR_CLR),
        .req      (PB),
        .wait_lamp(WAIT_B),
        .fault    (fault_b),
        .stuck    (stuck_b)
    );

    assign flags = stuck_a | stuck_b | fault_a | fault_b;

    // ERR either tracks the flags one cycle late or latches until cleared.
    always_comb begin
`ifdef TLC_ERR_STICKY_EN
        err_d = ERR_CLR ? 1'b0 : (err_q | flags);
`else
        err_d = flags;
`endif
    end

    // ERR register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign ERR = err_q;

endmodule
